// File: rtl/dm_pkg.sv
// Data-memory shared definitions: access-width codes and the store-buffer entry record.
package dm_pkg;

  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_BYTE = 2'b01;
  localparam logic [1:0] OP_HALF = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
  } sb_entry_t;

  // True when the access width is legal and the byte address is naturally aligned for it.
  function automatic logic store_legal(input logic [31:0] addr, input logic [1:0] op);
    logic ok;
    case (op)
      OP_WORD: ok = (addr[1:0] == 2'b00);
      OP_HALF: ok = !addr[0];
      OP_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry store for the store buffer; exposes per-entry valid bits and word addresses
// so the parent can run hazard compares against every pending store.
module store_buffer_fifo
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  sb_entry_t                  push_entry_i,
  input  logic                       pop_i,
  output sb_entry_t                  head_o,
  output logic [DEPTH-1:0]           valid_o,
  output logic [DEPTH-1:0][AW-1:0]   word_addr_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] entries_q;
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [PtrW:0]         count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      entries_q[tail_q] <= push_entry_i;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      word_addr_o[i] = entries_q[i].addr[AW+1:2];
    end
  end

  assign head_o  = entries_q[head_q];
  assign valid_o = valid_q;
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the data memory: queues stores, drains one per cycle,
// and gives loads priority on the single address port unless they hit a pending store.
module store_buffer
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_op,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_op,
  output logic        ld_stall,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [1:0]  dm_op,
  output logic        dm_we,
  output logic        err,
  output logic        empty
);

  sb_entry_t                push_entry;
  sb_entry_t                head_entry;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH-1:0][AW-1:0] entry_word_addr;
  logic                     fifo_full, fifo_empty;
  logic                     st_legal, st_accept, pop;
  logic                     pending_hit, incoming_hit, ld_hazard;
  logic                     err_q;

  assign st_legal   = store_legal(st_addr, st_op);
  assign st_ready   = !fifo_full && !rst;
  assign st_accept  = st_valid && st_ready && st_legal;
  assign push_entry = '{addr: st_addr, data: st_data, op: st_op};

  store_buffer_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (st_accept),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head_entry),
    .valid_o      (entry_valid),
    .word_addr_o  (entry_word_addr),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Word-granular compare ignores width and byte offset, so it may stall needlessly but never
  // lets a load overtake an overlapping store.
  always_comb begin
    pending_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_word_addr[i] == ld_addr[AW+1:2])) begin
        pending_hit = 1'b1;
      end
    end
  end

  assign incoming_hit = st_accept && (st_addr[AW+1:2] == ld_addr[AW+1:2]);
  assign ld_hazard    = ld_valid && (pending_hit || incoming_hit);
  assign ld_stall     = ld_hazard && !rst;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_op    = OP_WORD;
    dm_we    = 1'b0;
    pop      = 1'b0;
    if (rst) begin
      // Port stays idle so nothing pending is written while being discarded.
    end else if (ld_valid && !ld_hazard) begin
      dm_addr = ld_addr;
      dm_op   = ld_op;
    end else if (!fifo_empty) begin
      dm_addr  = head_entry.addr;
      dm_wdata = head_entry.data;
      dm_op    = head_entry.op;
      dm_we    = 1'b1;
      pop      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= st_valid && !st_legal;
    end
  end

  assign err   = err_q;
  assign empty = fifo_empty || rst;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued as stores are accepted
// and compared in order whenever the DUT drives a write.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_op;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_op;
  logic        ld_stall;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_op;
  logic        dm_we;
  logic        err;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [65:0] sb[$];

  store_buffer #(
    .DEPTH (4),
    .AW    (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_op    (st_op),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_op    (ld_op),
    .ld_stall (ld_stall),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_op    (dm_op),
    .dm_we    (dm_we),
    .err      (err),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Every write the DUT drives must be the oldest outstanding expected store.
  always @(negedge clk) begin
    logic [65:0] exp;
    if (dm_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h op=%b, none expected",
                 dm_addr, dm_wdata, dm_op);
      end else begin
        exp = sb.pop_front();
        if ({dm_addr, dm_wdata, dm_op} !== exp) begin
          errors++;
          $display("FAIL drain_order got addr=%h data=%h op=%b expected addr=%h data=%h op=%b",
                   dm_addr, dm_wdata, dm_op, exp[65:34], exp[33:2], exp[1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_op    = 2'b00;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_op    = 2'b00;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_op    = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if ({dm_we, st_ready, ld_stall, err, empty} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_outputs got we,rdy,stall,err,empty=%b expected 00001",
               {dm_we, st_ready, ld_stall, err, empty});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || st_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got empty=%b st_ready=%b expected 1 1", empty, st_ready);
    end
    tick();
  endtask

  task automatic test_single_store();
    drive_store(32'h10, 32'hDEADBEEF, 2'b00);
    sb.push_back({32'h10, 32'hDEADBEEF, 2'b00});
    #1;
    checks++;
    if (dm_we !== 1'b0) begin
      errors++;
      $display("FAIL store_latency got dm_we=%b expected 0 in enqueue cycle", dm_we);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({dm_we, dm_addr, dm_wdata, dm_op} !== {1'b1, 32'h10, 32'hDEADBEEF, 2'b00}) begin
      errors++;
      $display("FAIL single_store got we=%b addr=%h data=%h op=%b expected 1 10 deadbeef 00",
               dm_we, dm_addr, dm_wdata, dm_op);
    end
    tick();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    int not_ready = 0;
    int busy      = 0;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 2'b00);
      sb.push_back({32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 2'b00});
      #1;
      if (st_ready !== 1'b1) not_ready++;
      if (i > 0 && (dm_we !== 1'b1 || empty !== 1'b0)) busy++;
      tick();
    end
    idle_inputs();
    checks++;
    if (not_ready != 0 || busy != 0) begin
      errors++;
      $display("FAIL streaming got not_ready=%0d drain_gaps=%0d expected 0 0", not_ready, busy);
    end
    tick();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL streaming_empty got empty=%b expected 1", empty);
    end

    // Unrelated load holds the port, so the buffer fills.
    ld_valid = 1'b1;
    ld_addr  = 32'h800;
    ld_op    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h300 + 32'(4 * i), 32'hFACE0000 + 32'(i), 2'b00);
      #1;
      checks++;
      if (st_ready !== (i < 4) || dm_we !== 1'b0 || dm_addr !== 32'h800 || ld_stall !== 1'b0)
      begin
        errors++;
        $display("FAIL fill_%0d got rdy=%b we=%b addr=%h stall=%b expected rdy=%b we=0 addr=800",
                 i, st_ready, dm_we, dm_addr, ld_stall, (i < 4));
      end
      if (i < 4) sb.push_back({32'h300 + 32'(4 * i), 32'hFACE0000 + 32'(i), 2'b00});
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    checks++;
    if (empty !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL fill_drain got empty=%b left=%0d expected 1 0", empty, sb.size());
    end
  endtask

  task automatic test_hazard();
    drive_store(32'h21, 32'h000000A5, 2'b01);
    sb.push_back({32'h21, 32'h000000A5, 2'b01});
    tick();
    idle_inputs();
    ld_valid = 1'b1;
    ld_addr  = 32'h22;
    ld_op    = 2'b10;
    #1;
    checks++;
    if (ld_stall !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 32'h21) begin
      errors++;
      $display("FAIL hazard_stall got stall=%b we=%b addr=%h expected 1 1 21",
               ld_stall, dm_we, dm_addr);
    end
    tick();
    checks++;
    if (ld_stall !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'h22 || dm_op !== 2'b10) begin
      errors++;
      $display("FAIL hazard_release got stall=%b we=%b addr=%h op=%b expected 0 0 22 10",
               ld_stall, dm_we, dm_addr, dm_op);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_bypass();
    int writes = 0;
    ld_valid = 1'b1;
    ld_addr  = 32'h40;
    ld_op    = 2'b00;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h100 + 32'(4 * i), 32'h5A5A0000 + 32'(i), 2'b00);
      sb.push_back({32'h100 + 32'(4 * i), 32'h5A5A0000 + 32'(i), 2'b00});
      tick();
    end
    st_valid = 1'b0;
    #1;
    checks++;
    if (ld_stall !== 1'b0 || dm_we !== 1'b0 || dm_addr !== 32'h40) begin
      errors++;
      $display("FAIL bypass got stall=%b we=%b addr=%h expected 0 0 40", ld_stall, dm_we, dm_addr);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      #1;
      if (dm_we === 1'b1) writes++;
      tick();
    end
    checks++;
    if (writes != 3) begin
      errors++;
      $display("FAIL bypass_count got writes=%0d expected 3", writes);
    end
  endtask

  task automatic test_err();
    logic [31:0] bad_addr[3] = '{32'h02, 32'h40, 32'h13};
    logic [1:0]  bad_op[3]   = '{2'b00, 2'b11, 2'b10};
    for (int i = 0; i < 3; i++) begin
      drive_store(bad_addr[i], 32'hBAD0BAD0, bad_op[i]);
      tick();
      idle_inputs();
      #1;
      checks++;
      if (err !== 1'b1 || dm_we !== 1'b0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL err_pulse_%0d got err=%b we=%b empty=%b expected 1 0 1",
                 i, err, dm_we, empty);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL err_clear_%0d got err=%b expected 0", i, err);
      end
    end
  endtask

  task automatic test_reset_midway();
    ld_valid = 1'b1;
    ld_addr  = 32'h800;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h400 + 32'(4 * i), 32'h0BAD0000 + 32'(i), 2'b00);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if ({dm_we, st_ready, ld_stall, empty} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid got we,rdy,stall,empty=%b expected 0001",
               {dm_we, st_ready, ld_stall, empty});
    end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_after got we=%b empty=%b expected 0 1", dm_we, empty);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_back_to_back();
    test_hazard();
    test_load_bypass();
    test_err();
    test_reset_midway();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got %0d outstanding expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
